// File: rtl/therm_dwa_scheduler.sv
// Data-weighted-averaging scheduler for a 2**N-element thermometer array, with a one-entry output register.
// Define THERM_DWA_EN for the rotating pointer; otherwise the output is a plain thermometer code.
module therm_dwa_scheduler #(
  parameter int unsigned N = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N-1:0]      din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              ptr_clr,
  output logic [2**N-1:0]   dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [N-1:0]      ptr
);

  localparam int unsigned W = 2**N;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]   state;
  logic         accept;
  logic         drain;
  logic [N-1:0] p_eff;
  logic [N-1:0] off;
  logic [W-1:0] word;

  assign din_ready  = (state == EMPTY) || dout_ready;
  assign accept     = din_valid && din_ready;
  assign drain      = (state == FULL) && dout_ready;
  assign dout_valid = (state == FULL);

`ifdef THERM_DWA_EN
  logic [N-1:0] ptr_q;

  assign p_eff = ptr_clr ? '0 : ptr_q;
  assign ptr   = ptr_q;

  // N-bit wrap: d = 2**N-1 brings the pointer back to where it started.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= p_eff + din + N'(1);
    end else if (ptr_clr) begin
      ptr_q <= '0;
    end
  end
`else
  logic unused_ptr_clr;

  assign p_eff          = '0;
  assign ptr            = '0;
  assign unused_ptr_clr = ptr_clr;
`endif

  // Element i is on when its distance from the start pointer (mod 2**N) is within the code.
  always_comb begin
    word = '0;
    off  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      off     = N'(i) - p_eff;
      word[i] = (off <= din);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= EMPTY;
      dout  <= '0;
    end else if (accept) begin
      state <= FULL;
      dout  <= word;
    end else if (drain) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_therm_dwa_scheduler.sv
// Directed self-checking bench for therm_dwa_scheduler (N=8); expectations follow THERM_DWA_EN.
module tb_therm_dwa_scheduler;

  logic         clk = 1'b0;
  logic         resetn;
  logic [7:0]   din;
  logic         din_valid;
  logic         din_ready;
  logic         ptr_clr;
  logic [255:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic [7:0]   ptr;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned mp       = 0;
  logic [255:0] held;

  therm_dwa_scheduler #(.N(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ptr_clr    (ptr_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ptr        (ptr)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] exp_word(input int unsigned p, input int unsigned d);
    logic [255:0] w;
    w = '0;
    for (int unsigned k = 0; k <= d; k++) w[(p + k) % 256] = 1'b1;
    return w;
  endfunction

  function automatic int unsigned next_ptr(input int unsigned p, input int unsigned d);
`ifdef THERM_DWA_EN
    return (p + d + 1) % 256;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; din = '0; din_valid = 1'b0; ptr_clr = 1'b0; dout_ready = 1'b0;
    #1;
    chk("rst_din_ready", 256'(din_ready), 256'd1);
    step; step;
    chk("rst_dout", dout, '0);
    chk("rst_valid", 256'(dout_valid), 256'd0);
    chk("rst_ptr", 256'(ptr), 256'd0);
    resetn = 1'b1;
    step;
    chk("post_rst_din_ready", 256'(din_ready), 256'd1);

    // Rotation: d=3 then d=4, downstream always ready
    din = 8'd3; din_valid = 1'b1; dout_ready = 1'b1;
    step;
    chk("rot1_dout", dout, 256'hF);
    chk("rot1_valid", 256'(dout_valid), 256'd1);
    mp = next_ptr(mp, 3);
    chk("rot1_ptr", 256'(ptr), 256'(mp));
    din = 8'd4;
    step;
`ifdef THERM_DWA_EN
    chk("rot2_dout", dout, 256'h1F0);
    chk("rot2_ptr", 256'(ptr), 256'd9);
`else
    chk("rot2_dout", dout, 256'h1F);
    chk("rot2_ptr", 256'(ptr), 256'd0);
`endif
    mp = next_ptr(mp, 4);

    // Drain without accept, then din wiggle with no valid is ignored
    din_valid = 1'b0;
    step;
    chk("drain_valid", 256'(dout_valid), 256'd0);
    held = dout;
    din = 8'd77;
    step;
    chk("idle_valid", 256'(dout_valid), 256'd0);
    chk("idle_dout", dout, held);
    chk("idle_ptr", 256'(ptr), 256'(mp));

    // Move pointer to 250, then wrap with d=9 and full code d=255
    din = 8'd240; din_valid = 1'b1;
    step;
    chk("to250_dout", dout, exp_word(mp, 240));
    mp = next_ptr(mp, 240);
    chk("to250_ptr", 256'(ptr), 256'(mp));
    din = 8'd9;
    step;
    chk("wrap_dout", dout, exp_word(mp, 9));
`ifdef THERM_DWA_EN
    chk("wrap_dout_const", dout, {6'h3F, 246'd0, 4'hF});
    chk("wrap_ptr", 256'(ptr), 256'd4);
`endif
    mp = next_ptr(mp, 9);
    chk("wrap_ptr_model", 256'(ptr), 256'(mp));
    din = 8'd255;
    step;
    chk("full_dout", dout, '1);
    chk("full_ptr", 256'(ptr), 256'(mp));

    // Backpressure: FULL, downstream stalled, changing din
    dout_ready = 1'b0;
    for (int unsigned c = 0; c < 5; c++) begin
      din = 8'(c * 7 + 1);
      #1;
      chk("bp_din_ready", 256'(din_ready), 256'd0);
      step;
      chk("bp_dout", dout, '1);
      chk("bp_valid", 256'(dout_valid), 256'd1);
    end
    chk("bp_ptr", 256'(ptr), 256'(mp));
    din = 8'd5; dout_ready = 1'b1;
    #1;
    chk("bp_release_ready", 256'(din_ready), 256'd1);
    step;
    chk("bp_reload_dout", dout, exp_word(mp, 5));
    chk("bp_reload_valid", 256'(dout_valid), 256'd1);
    mp = next_ptr(mp, 5);
    chk("bp_reload_ptr", 256'(ptr), 256'(mp));

    // ptr_clr priority: bring pointer to 17 (DWA), then clear with accept of d=2
    din = 8'd6;
    step;
    mp = next_ptr(mp, 6);
`ifdef THERM_DWA_EN
    chk("p17_ptr", 256'(ptr), 256'd17);
`endif
    din = 8'd2; ptr_clr = 1'b1;
    step;
    chk("clr_acc_dout", dout, 256'h7);
    mp = next_ptr(0, 2);
    chk("clr_acc_ptr", 256'(ptr), 256'(mp));
    din_valid = 1'b0; dout_ready = 1'b0;
    step;
    chk("clr_only_ptr", 256'(ptr), 256'd0);
    chk("clr_only_dout", dout, 256'h7);
    chk("clr_only_valid", 256'(dout_valid), 256'd1);
    ptr_clr = 1'b0;
    mp = 0;

    // Accept d=3 twice from a cleared pointer
    din = 8'd3; din_valid = 1'b1; dout_ready = 1'b1;
    step;
    chk("twice1_dout", dout, 256'hF);
    mp = next_ptr(mp, 3);
    step;
    chk("twice2_dout", dout, exp_word(mp, 3));
    mp = next_ptr(mp, 3);
    chk("twice2_ptr", 256'(ptr), 256'(mp));

    // Reset mid-stream while FULL
    din_valid = 1'b0; dout_ready = 1'b0;
    step;
    chk("pre_rst_valid", 256'(dout_valid), 256'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_dout", dout, '0);
    chk("mid_rst_valid", 256'(dout_valid), 256'd0);
    chk("mid_rst_ptr", 256'(ptr), 256'd0);
    chk("mid_rst_din_ready", 256'(din_ready), 256'd1);
    step;
    resetn = 1'b1;
    step;
    chk("after_rst_valid", 256'(dout_valid), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
